// File: rtl/plru_pkg.sv
// +--------------------------------------------------------------------+
// | plru_pkg : shared types and tree-PLRU helpers for plru_set_ctrl     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package plru_pkg;

    localparam int PLRU_BITS = 3;
    localparam int NUM_WAYS  = 4;

    typedef logic [1:0]           way_t;
    typedef logic [PLRU_BITS-1:0] plru_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } plru_ctrl_state_t;

    // t[0] picks the half, t[1]/t[2] pick the way inside the left/right half.
    function automatic way_t plru_victim(input plru_t t);
        return {t[0], (t[0] ? t[2] : t[1])};
    endfunction

    function automatic plru_t plru_update(input plru_t t, input way_t w);
        plru_t n;
        n    = t;
        n[0] = ~w[1];
        if (w[1]) begin
            n[2] = ~w[0];
        end else begin
            n[1] = ~w[0];
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/plru_victim_sel.sv
// +--------------------------------------------------------------------+
// | plru_victim_sel : picks the used way and computes the next tree     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module plru_victim_sel
    import plru_pkg::*;
(
    input  logic [2:0] tree,
    input  logic       hit,
    input  logic [1:0] hit_way,
    output logic [1:0] used_way,
    output logic [2:0] next_tree
);

    assign used_way  = hit ? hit_way : plru_victim(tree);
    assign next_tree = plru_update(tree, used_way);

endmodule

`default_nettype wire

// File: rtl/plru_set_ctrl.sv
// +--------------------------------------------------------------------+
// | plru_set_ctrl : per-set 4-way tree-PLRU controller with init sweep  |
// | Optional PLRU_PERF_CNT_EN adds saturating hit/miss counters. Rev 1.0|
// +--------------------------------------------------------------------+
`default_nettype none

module plru_set_ctrl
    import plru_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int SET_W    = $clog2(NUM_SETS)
)
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic             req_hit,
    input  logic [1:0]       req_way,
    output logic             rsp_valid,
    output logic [1:0]       rsp_way,
    output logic             init_busy
`ifdef PLRU_PERF_CNT_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
`endif
);

    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    plru_ctrl_state_t state;
    plru_ctrl_state_t state_next;
    logic [SET_W-1:0] init_cnt;
    plru_t            plru_table [NUM_SETS];

    logic             accept;
    plru_t            cur_tree;
    plru_t            new_tree;
    way_t             used_way;

    assign accept   = req_valid && req_ready;
    assign cur_tree = plru_table[req_set];

    plru_victim_sel u_victim_sel (
        .tree      (cur_tree),
        .hit       (req_hit),
        .hit_way   (req_way),
        .used_way  (used_way),
        .next_tree (new_tree)
    );

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        init_busy  = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                if (!flush && (init_cnt == LAST_SET)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                req_ready = 1'b1;
                if (flush) begin
                    state_next = INIT;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_way   <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= accept;
            if (accept) begin
                rsp_way <= used_way;
            end
            // Held at zero outside INIT so every sweep starts from set 0.
            init_cnt <= (state == INIT && !flush) ? init_cnt + 1'b1 : '0;
        end
    end

    // Read and write share the edge, so same-set back-to-back needs no bypass.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            plru_table[init_cnt] <= '0;
        end else if (accept) begin
            plru_table[req_set] <= new_tree;
        end
    end

`ifdef PLRU_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (req_hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_plru_set_ctrl.sv
// Scoreboard bench for plru_set_ctrl: directed scenarios then random traffic
// against a per-set binary-tree reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_plru_set_ctrl;

    localparam int NUM_SETS = 16;
    localparam int SET_W    = 4;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             flush     = 1'b0;
    logic             req_valid = 1'b0;
    logic [SET_W-1:0] req_set   = '0;
    logic             req_hit   = 1'b0;
    logic [1:0]       req_way   = '0;
    logic             req_ready;
    logic             rsp_valid;
    logic [1:0]       rsp_way;
    logic             init_busy;
`ifdef PLRU_PERF_CNT_EN
    logic [31:0]      hit_cnt;
    logic [31:0]      miss_cnt;
`endif

    plru_set_ctrl #(.NUM_SETS(NUM_SETS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_set   (req_set),
        .req_hit   (req_hit),
        .req_way   (req_way),
        .rsp_valid (rsp_valid),
        .rsp_way   (rsp_way),
        .init_busy (init_busy)
`ifdef PLRU_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    // node[s][0]: which half is older (0 left, 1 right)
    // node[s][1]/[2]: which way inside left/right half is older
    int  node [NUM_SETS][3];
    longint m_hit  = 0;
    longint m_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < NUM_SETS; s++)
            for (int k = 0; k < 3; k++)
                node[s][k] = 0;
    endfunction

    function automatic int model_access(input int s, input bit hit, input int w);
        int used;
        if (hit) used = w;
        else if (node[s][0] == 0) used = node[s][1];
        else used = 2 + node[s][2];
        // Point every node on the path away from the way just used.
        node[s][0] = (used < 2) ? 1 : 0;
        if (used < 2) node[s][1] = 1 - (used % 2);
        else          node[s][2] = 1 - (used % 2);
        if (hit) m_hit++; else m_miss++;
        return used;
    endfunction

    // Applies inputs for one clock edge; exp_override >= 0 forces the expected way.
    task automatic drive(input bit v, input int s, input bit h, input int w,
                         input bit f, input bit rn, input int exp_override);
        int u;
        @(negedge clock);
        req_valid = v;
        req_set   = SET_W'(s);
        req_hit   = h;
        req_way   = 2'(w);
        flush     = f;
        reset_n   = rn;
        if (!rn) begin
            model_clear();
            m_hit  = 0;
            m_miss = 0;
        end else begin
            if (v && req_ready) begin
                u = model_access(s, h, w);
                exp_q.push_back((exp_override >= 0) ? exp_override : u);
            end
            if (f) model_clear();
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 1, -1);
    endtask

    // Call right after a drive; counts busy negedges until req_ready rises.
    task automatic wait_init();
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) break;
            if (init_busy) n++;
            @(negedge clock);
        end
        check("init_done", req_ready, 1);
        check("init_cycles", n, NUM_SETS);
        check("init_busy_off", init_busy, 0);
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_valid", rsp_valid, 1);
                check("rsp_way", rsp_way, e);
            end else begin
                check("rsp_idle", rsp_valid, 0);
            end
        end
    end

    initial begin : stim
        model_clear();
        drive(0, 0, 0, 0, 0, 0, -1);
        drive(1, 2, 0, 0, 0, 0, -1);
        check("reset_busy", init_busy, 1);
        check("reset_ready", req_ready, 0);
        check("reset_rsp_way", rsp_way, 0);
        idle();
        wait_init();

        // Fresh set victims
        drive(1, 3, 0, 0, 0, 1, 0);
        drive(1, 3, 0, 0, 0, 1, 2);
        drive(1, 3, 0, 0, 0, 1, 1);
        drive(1, 3, 0, 0, 0, 1, 3);
        idle();

        // Hits steer the victim
        drive(1, 5, 1, 0, 0, 1, 0);
        drive(1, 5, 0, 0, 0, 1, 2);
        drive(1, 5, 1, 2, 0, 1, 2);
        drive(1, 5, 0, 0, 0, 1, 1);
        idle();

        // Back-to-back same set
        drive(1, 7, 0, 0, 0, 1, 0);
        drive(1, 7, 0, 0, 0, 1, 2);

        // Flush with an accepted hit
        drive(1, 1, 1, 3, 1, 1, 3);
        idle();
        check("flush_busy", init_busy, 1);
        wait_init();
        drive(1, 1, 0, 0, 0, 1, 0);
        drive(1, 5, 0, 0, 0, 1, 0);

        // Reset the cycle after an accept, with a request pending
        drive(1, 2, 1, 1, 0, 1, 1);
        drive(1, 2, 0, 0, 0, 0, -1);
        idle();
        check("rst_busy", init_busy, 1);
        check("rst_ready", req_ready, 0);
`ifdef PLRU_PERF_CNT_EN
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
`endif
        wait_init();

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, NUM_SETS - 1),
                  $urandom_range(0, 1),
                  $urandom_range(0, 3),
                  (r >= 3 && r < 8),
                  !(r < 3),
                  -1);
        end
        idle();
        idle();
`ifdef PLRU_PERF_CNT_EN
        check("hit_cnt", hit_cnt, m_hit);
        check("miss_cnt", miss_cnt, m_miss);
`endif
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
